// File: rtl/systolic_pkg.sv
// Shared systolic-array package: array operation codes used by the load
// controller and the one-hot state encoding of the job scheduler.
package systolic_pkg;

  // Operation codes of the array load controller.
  typedef enum logic [1:0] {
    ARR_LOAD = 2'd0,
    ARR_MAC  = 2'd1,
    ARR_OUT  = 2'd2
  } arr_op_e;

  // Scheduler states, one-hot.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CLEAR = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_MAC   = 5'b01000,
    ST_DRAIN = 5'b10000
  } sched_state_e;

endpackage

// File: rtl/systolic_sched.sv
// Job scheduler for a SIZE x SIZE systolic array. Accepts a job of reduction
// depth K, clears the accumulators, waits for the operand FIFOs, enables the
// PEs for K + 2*(SIZE-1) cycles (skew fill plus drain), then hands out the
// SIZE result rows one per out_val/out_rdy handshake.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_val/cmd_rdy       job request handshake, cmd_len = K
//   arr_clr               one-cycle accumulator clear
//   arr_full              operand FIFOs loaded
//   arr_mac_en            PE accumulate enable
//   arr_row_sel           result row selected onto the output
//   out_val/out_rdy       result row handshake
//   busy                  any state other than IDLE
//   done                  pulse on acceptance of the last row
module systolic_sched
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_val,
  output logic                     cmd_rdy,
  input  logic [CNT_W-1:0]         cmd_len,
  output logic                     arr_clr,
  input  logic                     arr_full,
  output logic                     arr_mac_en,
  output logic [$clog2(SIZE)-1:0]  arr_row_sel,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ROW_W = $clog2(SIZE);
  // One extra bit so the longest job (K = 2^CNT_W-1) cannot wrap.
  localparam int unsigned CYC_W = CNT_W + 1;
  localparam int unsigned SKEW  = 2 * (SIZE - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CYC_W-1:0] mac_last;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cyc_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      row_q   <= row_d;
    end
  end

  // Next-state, counter update and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cyc_d      = cyc_q;
    row_d      = row_q;
    cmd_rdy    = 1'b0;
    arr_clr    = 1'b0;
    arr_mac_en = 1'b0;
    out_val    = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    // Index of the final MAC cycle, counting from 0.
    mac_last   = CYC_W'(len_q) + CYC_W'(SKEW - 1);

    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          len_d   = cmd_len;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        arr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (arr_full) begin
          cyc_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        arr_mac_en = 1'b1;
        if (cyc_q == mac_last) begin
          cyc_d   = '0;
          row_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DRAIN: begin
        out_val = 1'b1;
        if (out_rdy) begin
          if (row_q == ROW_W'(SIZE - 1)) begin
            done    = 1'b1;
            row_d   = '0;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset cycle: everything quiet, including cmd_rdy, before the state flop updates.
    if (rst) begin
      cmd_rdy    = 1'b0;
      arr_clr    = 1'b0;
      arr_mac_en = 1'b0;
      out_val    = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
    end
  end

  assign arr_row_sel = rst ? '0 : row_q;

endmodule

// File: tb/tb_systolic_sched.sv
// Self-checking bench for systolic_sched. Each job is described by its
// timeline: accept at cycle 0, clear at 1, wait_n WAIT cycles, then
// K + 2*(SIZE-1) MAC cycles, then a drain that lasts until SIZE handshakes.
module tb_systolic_sched;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ROW_W = $clog2(SIZE);

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_val;
  logic             cmd_rdy;
  logic [CNT_W-1:0] cmd_len;
  logic             arr_clr;
  logic             arr_full;
  logic             arr_mac_en;
  logic [ROW_W-1:0] arr_row_sel;
  logic             out_val;
  logic             out_rdy;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_sched #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_val    (cmd_val),
    .cmd_rdy    (cmd_rdy),
    .cmd_len    (cmd_len),
    .arr_clr    (arr_clr),
    .arr_full   (arr_full),
    .arr_mac_en (arr_mac_en),
    .arr_row_sel(arr_row_sel),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_rdy, input bit e_clr, input bit e_mac,
                         input bit e_out, input bit e_busy, input bit e_done, input int e_row);
    chk({tag, ".cmd_rdy"}, 32'(cmd_rdy), 32'(e_rdy));
    chk({tag, ".arr_clr"}, 32'(arr_clr), 32'(e_clr));
    chk({tag, ".mac_en"},  32'(arr_mac_en), 32'(e_mac));
    chk({tag, ".out_val"}, 32'(out_val), 32'(e_out));
    chk({tag, ".busy"},    32'(busy), 32'(e_busy));
    chk({tag, ".done"},    32'(done), 32'(e_done));
    chk({tag, ".row_sel"}, 32'(arr_row_sel), 32'(e_row));
    chk({tag, ".mutex"},   32'($countones({arr_clr, arr_mac_en, out_val}) <= 1), 32'd1);
  endtask

  // Runs one job starting #1 after a rising edge with the DUT in IDLE.
  // rdy_mode: 0 = out_rdy always 1, 1 = pattern 1,0,0,1,1,0,1, 2 = random.
  // abort_idx >= 0 pulses rst in that cycle of the job timeline.
  task automatic run_job(input string tag, input int k, input int wait_n, input int rdy_mode,
                         input bit hold_val, input int abort_idx);
    int        mac_len     = k + 2 * (SIZE - 1);
    int        mac_first   = wait_n + 2;
    int        drain_first = mac_first + mac_len;
    int        hs          = 0;
    bit        fin         = 1'b0;
    bit        e_out, e_done;
    logic [6:0] pat        = 7'b1011001;
    for (int idx = 0; idx < 3000 && !fin; idx++) begin
      cmd_val  = (idx == 0) || hold_val;
      cmd_len  = (idx == 0) ? CNT_W'(k) : CNT_W'($urandom);
      arr_full = (idx < 2) ? 1'($urandom_range(0, 1)) : (idx >= wait_n + 1);
      if (idx >= drain_first) begin
        case (rdy_mode)
          0:       out_rdy = 1'b1;
          1:       out_rdy = (idx - drain_first < 7) ? pat[idx - drain_first] : 1'b1;
          default: out_rdy = 1'($urandom_range(0, 1));
        endcase
      end else begin
        out_rdy = 1'($urandom_range(0, 1));
      end
      rst = (idx == abort_idx);
      @(negedge clk);
      if (rst) begin
        chk_all({tag, ".rst"}, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst     = 1'b0;
        cmd_val = 1'b0;
        @(negedge clk);
        chk_all({tag, ".post_rst"}, 1, 0, 0, 0, 0, 0, 0);
        fin = 1'b1;
      end else begin
        e_out  = (idx >= drain_first);
        e_done = e_out && out_rdy && (hs == SIZE - 1);
        chk_all(tag, idx == 0, idx == 1, idx >= mac_first && idx < drain_first,
                e_out, idx > 0, e_done, e_out ? hs : 0);
        if (e_out && out_rdy) hs++;
        if (e_done) fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!fin) chk({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int k, w, m;
    rst      = 1'b1;
    cmd_val  = 1'b0;
    cmd_len  = '0;
    arr_full = 1'b0;
    out_rdy  = 1'b0;

    // Reset held: all outputs low, even with inputs active.
    repeat (3) begin
      @(posedge clk); #1;
      cmd_val  = 1'b1;
      arr_full = 1'b1;
      out_rdy  = 1'b1;
      @(negedge clk);
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    end

    // Idle after reset; arr_full must be ignored.
    @(posedge clk); #1;
    rst     = 1'b0;
    cmd_val = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_all("idle", 1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end

    run_job("k3",      3,  1, 0, 1'b0, -1);
    run_job("k0",      0,  1, 0, 1'b0, -1);
    run_job("stall",   5,  1, 1, 1'b0, -1);
    run_job("wait10",  2, 10, 0, 1'b0, -1);
    run_job("b2b_a",   4,  1, 0, 1'b1, -1);
    run_job("b2b_b",   1,  1, 0, 1'b1, -1);
    // Fifth MAC cycle is timeline index wait_n + 2 + 4.
    run_job("abort_mac", 6, 1, 0, 1'b0, 1 + 2 + 4);
    run_job("after_abort", 3, 2, 2, 1'b0, -1);
    // Second drain cycle of a K=2 job: 1 + 2 + 2 + 6 + 1.
    run_job("abort_drain", 2, 1, 1, 1'b0, 12);
    run_job("kmax",  255,  1, 2, 1'b0, -1);

    for (int j = 0; j < 6; j++) begin
      k = $urandom_range(0, 20);
      w = $urandom_range(1, 5);
      m = $urandom_range(0, 2);
      run_job($sformatf("rand%0d", j), k, w, m, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
